dimm_cmd_responder: RTL and testbench

DIMM_CMD_RESPONDER -- requirements
Module: dimm_cmd_responder

---
 rtl/dimm_pkg.sv | 41 ++++
 rtl/dimm_burst_engine.sv | 102 ++++++++++
 rtl/dimm_cmd_responder.sv | 144 ++++++++++++++
 tb/tb_dimm_cmd_responder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dimm_pkg.sv
// Command/error encodings, timing defaults and bank indexing shared by the
// DIMM command responder and its burst engine.
package dimm_pkg;

    typedef enum logic [2:0] {
        CMD_NOP  = 3'd0,
        CMD_ACT0 = 3'd1,
        CMD_ACT1 = 3'd2,
        CMD_RD0  = 3'd3,
        CMD_RD1  = 3'd4,
        CMD_WR0  = 3'd5,
        CMD_WR1  = 3'd6,
        CMD_PRE  = 3'd7
    } cmd_e;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_BANK_OPEN = 3'd1,
        ERR_TRP       = 3'd2,
        ERR_BANK_IDLE = 3'd3,
        ERR_TRCD      = 3'd4,
        ERR_PAIR      = 3'd5,
        ERR_BUSY      = 3'd6,
        ERR_PRE_EARLY = 3'd7
    } err_e;

    typedef logic [4:0] bank_idx_t;

    localparam int NUM_BANKS  = 32;
    localparam int TRCD_DEF   = 39;
    localparam int TCL_DEF    = 40;
    localparam int TRP_DEF    = 39;
    localparam int TBURST_DEF = 8;

    // The timer is loaded on the edge after the command and a command is legal
    // when it reads 0, so "legal from command cycle + d" needs a load of d-1.
    function automatic logic [7:0] timer_load(input int d);
        return (d <= 1) ? 8'd0 : 8'(d - 1);
    endfunction

endpackage

// File: rtl/dimm_burst_engine.sv
// Read/write burst sequencer: waits out the CAS latency, then streams TBURST
// beats, generating rd_valid/rd_data or wr_req and a trailing wr_done pulse.
//
// state   | meaning
// BE_IDLE | no burst in flight, ready to accept start
// BE_WAIT | counting down CAS latency
// BE_BEAT | driving one data beat per cycle
module dimm_burst_engine
    import dimm_pkg::*;
#(
    parameter int TCL    = TCL_DEF,
    parameter int TBURST = TBURST_DEF
) (
    input  logic            dimm_clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            start_wr,
    input  logic [15:0]     start_row,
    input  bank_idx_t       start_bank,
    input  logic [5:0]      start_col,
    output logic            busy,
    output logic            rd_valid,
    output logic [63:0]     rd_data,
    output logic            wr_req,
    output logic            wr_done
);

    typedef enum logic [1:0] {BE_IDLE, BE_WAIT, BE_BEAT} be_state_e;

    // Start is seen one edge after the command and the first beat is itself
    // registered, so the latency counter covers TCL-2 cycles (TCL >= 2).
    localparam logic [7:0] WAIT_LOAD = 8'(TCL - 2);
    localparam logic [7:0] LAST_BEAT = 8'(TBURST - 1);

    be_state_e   state, state_nxt;
    logic [7:0]  wait_cnt, wait_nxt;
    logic [7:0]  beat, beat_nxt;
    logic        done_nxt;
    logic        is_wr;
    logic [15:0] row;
    bank_idx_t   bank;
    logic [5:0]  col;

    always_ff @(posedge dimm_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BE_IDLE;
            wait_cnt <= '0;
            beat     <= '0;
            wr_done  <= 1'b0;
            is_wr    <= 1'b0;
            row      <= '0;
            bank     <= '0;
            col      <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            beat     <= beat_nxt;
            wr_done  <= done_nxt;
            if (state == BE_IDLE && start) begin
                is_wr <= start_wr;
                row   <= start_row;
                bank  <= start_bank;
                col   <= start_col;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        beat_nxt  = beat;
        done_nxt  = 1'b0;
        case (state)
            BE_IDLE: begin
                if (start) begin
                    state_nxt = BE_WAIT;
                    wait_nxt  = WAIT_LOAD;
                    beat_nxt  = '0;
                end
            end
            BE_WAIT: begin
                if (wait_cnt == 8'd0) state_nxt = BE_BEAT;
                else                  wait_nxt  = wait_cnt - 8'd1;
            end
            BE_BEAT: begin
                if (beat == LAST_BEAT) begin
                    state_nxt = BE_IDLE;
                    done_nxt  = is_wr;
                end else begin
                    beat_nxt = beat + 8'd1;
                end
            end
            default: state_nxt = BE_IDLE;
        endcase
    end

    assign busy     = (state != BE_IDLE);
    assign rd_valid = (state == BE_BEAT) && !is_wr;
    assign wr_req   = (state == BE_BEAT) && is_wr;
    assign rd_data  = rd_valid ? {34'b0, row, bank, col, beat[2:0]} : 64'd0;

endmodule

// File: rtl/dimm_cmd_responder.sv
// DIMM command responder: pairs two-cycle commands, tracks per-bank open state
// and timing, flags protocol errors and launches read/write bursts.
module dimm_cmd_responder
    import dimm_pkg::*;
#(
    parameter int TRCD   = TRCD_DEF,
    parameter int TCL    = TCL_DEF,
    parameter int TRP    = TRP_DEF,
    parameter int TBURST = TBURST_DEF
) (
    input  logic        dimm_clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    input  logic [2:0]  cmd_code,
    input  logic [2:0]  cmd_bg,
    input  logic [1:0]  cmd_ba,
    input  logic [15:0] cmd_row,
    input  logic [5:0]  cmd_col,
    output logic        rd_valid,
    output logic [63:0] rd_data,
    output logic        wr_req,
    input  logic [63:0] wr_data,
    output logic        wr_done,
    output logic [31:0] bank_active,
    output logic        err_valid,
    output logic [2:0]  err_code
);

    localparam logic [7:0] ACT_LOAD   = timer_load(TRCD);
    localparam logic [7:0] BURST_LOAD = timer_load(TCL + TBURST);
    localparam logic [7:0] PRE_LOAD   = timer_load(TRP);

    logic        pend_valid;
    logic [2:0]  pend_code;
    bank_idx_t   pend_idx;
    logic [15:0] pend_row;
    logic [5:0]  pend_col;

    logic [15:0] bank_row [NUM_BANKS];
    logic [7:0]  bank_tmr [NUM_BANKS];

    cmd_e      code;
    bank_idx_t idx;
    logic      cur_first, cur_second, pair_ok, err_pair;
    logic      idx_active, tmr_zero, busy;
    logic      exec_act, exec_rd, exec_wr, exec_pre;
    err_e      exec_err, err_nxt;

    // Write payload is acknowledged through wr_req only; it is not stored.
    logic unused_wr_data;
    assign unused_wr_data = ^wr_data;

    always_comb begin
        code       = cmd_valid ? cmd_e'(cmd_code) : CMD_NOP;
        idx        = {cmd_bg, cmd_ba};
        cur_first  = (code == CMD_ACT0) || (code == CMD_RD0) || (code == CMD_WR0);
        cur_second = (code == CMD_ACT1) || (code == CMD_RD1) || (code == CMD_WR1);
        pair_ok    = pend_valid && cur_second && (cmd_code == pend_code + 3'd1) &&
                     (idx == pend_idx);
        // A broken pair and an orphan second half are both pairing errors.
        err_pair   = (pend_valid && !pair_ok) || (cur_second && !pair_ok);
        idx_active = bank_active[idx];
        tmr_zero   = (bank_tmr[idx] == 8'd0);

        exec_err = ERR_NONE;
        if (pair_ok && code == CMD_ACT1) begin
            if (idx_active)     exec_err = ERR_BANK_OPEN;
            else if (!tmr_zero) exec_err = ERR_TRP;
        end else if (pair_ok) begin
            if (!idx_active)    exec_err = ERR_BANK_IDLE;
            else if (!tmr_zero) exec_err = ERR_TRCD;
            else if (busy)      exec_err = ERR_BUSY;
        end else if (code == CMD_PRE) begin
            if (!idx_active)    exec_err = ERR_BANK_IDLE;
            else if (!tmr_zero) exec_err = ERR_PRE_EARLY;
        end

        exec_act = pair_ok && (code == CMD_ACT1) && (exec_err == ERR_NONE);
        exec_rd  = pair_ok && (code == CMD_RD1)  && (exec_err == ERR_NONE);
        exec_wr  = pair_ok && (code == CMD_WR1)  && (exec_err == ERR_NONE);
        exec_pre = (code == CMD_PRE) && (exec_err == ERR_NONE);
        err_nxt  = err_pair ? ERR_PAIR : exec_err;
    end

    always_ff @(posedge dimm_clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid  <= 1'b0;
            pend_code   <= '0;
            pend_idx    <= '0;
            pend_row    <= '0;
            pend_col    <= '0;
            bank_active <= '0;
            err_valid   <= 1'b0;
            err_code    <= '0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                bank_row[i] <= '0;
                bank_tmr[i] <= '0;
            end
        end else begin
            pend_valid <= cur_first;
            if (cur_first) begin
                pend_code <= cmd_code;
                pend_idx  <= idx;
                pend_row  <= cmd_row;
                pend_col  <= cmd_col;
            end
            err_valid <= (err_nxt != ERR_NONE);
            err_code  <= err_nxt;

            for (int i = 0; i < NUM_BANKS; i++) begin
                if (bank_tmr[i] != 8'd0) bank_tmr[i] <= bank_tmr[i] - 8'd1;
            end
            if (exec_act) begin
                bank_active[idx] <= 1'b1;
                bank_row[idx]    <= pend_row;
                bank_tmr[idx]    <= ACT_LOAD;
            end
            if (exec_rd || exec_wr) bank_tmr[idx] <= BURST_LOAD;
            if (exec_pre) begin
                bank_active[idx] <= 1'b0;
                bank_tmr[idx]    <= PRE_LOAD;
            end
        end
    end

    dimm_burst_engine #(
        .TCL    (TCL),
        .TBURST (TBURST)
    ) u_burst (
        .dimm_clk   (dimm_clk),
        .rst_n      (rst_n),
        .start      (exec_rd || exec_wr),
        .start_wr   (exec_wr),
        .start_row  (bank_row[idx]),
        .start_bank (idx),
        .start_col  (pend_col),
        .busy       (busy),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .wr_req     (wr_req),
        .wr_done    (wr_done)
    );

endmodule

// File: tb/tb_dimm_cmd_responder.sv
// Scoreboard bench for dimm_cmd_responder: directed command timelines push
// expected beats/errors into queues that a negedge monitor drains.
module tb_dimm_cmd_responder;
    import dimm_pkg::*;

    localparam int TCL    = 40;
    localparam int TBURST = 8;

    logic        dimm_clk  = 1'b0;
    logic        rst_n     = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd_code  = '0;
    logic [2:0]  cmd_bg    = '0;
    logic [1:0]  cmd_ba    = '0;
    logic [15:0] cmd_row   = '0;
    logic [5:0]  cmd_col   = '0;
    logic [63:0] wr_data   = 64'h0123_4567_89ab_cdef;
    logic        rd_valid, wr_req, wr_done, err_valid;
    logic [63:0] rd_data;
    logic [31:0] bank_active;
    logic [2:0]  err_code;

    dimm_cmd_responder dut (
        .dimm_clk    (dimm_clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_code    (cmd_code),
        .cmd_bg      (cmd_bg),
        .cmd_ba      (cmd_ba),
        .cmd_row     (cmd_row),
        .cmd_col     (cmd_col),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .wr_req      (wr_req),
        .wr_data     (wr_data),
        .wr_done     (wr_done),
        .bank_active (bank_active),
        .err_valid   (err_valid),
        .err_code    (err_code)
    );

    always #5 dimm_clk = ~dimm_clk;

    int cyc = 0;
    always @(posedge dimm_clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int base    = 0;

    typedef struct {
        int          cyc;
        logic [63:0] val;
    } exp_t;

    exp_t rd_q[$];
    exp_t err_q[$];
    exp_t wrq_q[$];
    exp_t done_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc - base);
        end
    endtask

    // Monitor: compare every observed output event against the front of its queue.
    exp_t e;
    always @(negedge dimm_clk) begin
        if (rst_n) begin
            if (rd_valid) begin
                if (rd_q.size() == 0) chk("rd_unexpected", rd_valid, 0);
                else begin
                    e = rd_q.pop_front();
                    chk("rd_cycle", cyc, e.cyc);
                    chk("rd_data", rd_data, e.val);
                end
            end else if (rd_q.size() != 0 && rd_q[0].cyc <= cyc) begin
                e = rd_q.pop_front();
                chk("rd_missing", rd_valid, 1);
            end

            if (err_valid) begin
                if (err_q.size() == 0) chk("err_unexpected", {err_valid, err_code}, 0);
                else begin
                    e = err_q.pop_front();
                    chk("err_cycle", cyc, e.cyc);
                    chk("err_code", err_code, e.val);
                end
            end else if (err_q.size() != 0 && err_q[0].cyc <= cyc) begin
                e = err_q.pop_front();
                chk("err_missing", err_valid, 1);
            end

            if (wr_req) begin
                if (wrq_q.size() == 0) chk("wr_req_unexpected", wr_req, 0);
                else begin
                    e = wrq_q.pop_front();
                    chk("wr_req_cycle", cyc, e.cyc);
                end
            end else if (wrq_q.size() != 0 && wrq_q[0].cyc <= cyc) begin
                e = wrq_q.pop_front();
                chk("wr_req_missing", wr_req, 1);
            end

            if (wr_done) begin
                if (done_q.size() == 0) chk("wr_done_unexpected", wr_done, 0);
                else begin
                    e = done_q.pop_front();
                    chk("wr_done_cycle", cyc, e.cyc);
                end
            end else if (done_q.size() != 0 && done_q[0].cyc <= cyc) begin
                e = done_q.pop_front();
                chk("wr_done_missing", wr_done, 1);
            end
        end
    end

    task automatic clear_q();
        rd_q.delete();
        err_q.delete();
        wrq_q.delete();
        done_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_q();
        repeat (3) @(posedge dimm_clk);
        #1 rst_n = 1'b1;
        base = cyc;
    endtask

    task automatic go_to(input int n);
        while (cyc < base + n) begin
            @(posedge dimm_clk);
            #1;
        end
    endtask

    task automatic send(input logic [2:0] c, input logic [2:0] bg, input logic [1:0] ba,
                        input logic [15:0] row, input logic [5:0] col);
        cmd_valid = 1'b1;
        cmd_code  = c;
        cmd_bg    = bg;
        cmd_ba    = ba;
        cmd_row   = row;
        cmd_col   = col;
        @(posedge dimm_clk);
        #1;
        cmd_valid = 1'b0;
        cmd_code  = CMD_NOP;
    endtask

    task automatic pair_at(input int n, input logic [2:0] first, input logic [2:0] bg,
                           input logic [1:0] ba, input logic [15:0] row, input logic [5:0] col);
        go_to(n);
        send(first, bg, ba, row, col);
        send(first + 3'd1, bg, ba, row, col);
    endtask

    task automatic one_at(input int n, input logic [2:0] c, input logic [2:0] bg, input logic [1:0] ba);
        go_to(n);
        send(c, bg, ba, 16'd0, 6'd0);
    endtask

    task automatic exp_err(input int n, input logic [2:0] code);
        err_q.push_back('{cyc: base + n + 1, val: 64'(code)});
    endtask

    task automatic exp_rd(input int n, input logic [15:0] row, input logic [2:0] bg,
                          input logic [1:0] ba, input logic [5:0] col);
        for (int k = 0; k < TBURST; k++) begin
            logic [2:0] kb;
            kb = 3'(k);
            rd_q.push_back('{cyc: base + n + TCL + k, val: {34'b0, row, bg, ba, col, kb}});
        end
    endtask

    task automatic exp_wr(input int n);
        for (int k = 0; k < TBURST; k++) wrq_q.push_back('{cyc: base + n + TCL + k, val: 64'd0});
        done_q.push_back('{cyc: base + n + TCL + TBURST, val: 64'd0});
    endtask

    task automatic drain(input int n);
        go_to(n);
        chk("rd_left", rd_q.size(), 0);
        chk("err_left", err_q.size(), 0);
        chk("wr_req_left", wrq_q.size(), 0);
        chk("wr_done_left", done_q.size(), 0);
    endtask

    // Read on bank 9, PRE boundary at 88/89, then ACT1 either one cycle early or exactly on time.
    task automatic scn_pre_act(input bit on_time);
        do_reset();
        pair_at(0, CMD_ACT0, 3'd2, 2'd1, 16'h1234, 6'd0);
        chk("act_open_b9", bank_active[9], 1);
        exp_rd(41, 16'h1234, 3'd2, 2'd1, 6'h05);
        pair_at(40, CMD_RD0, 3'd2, 2'd1, 16'd0, 6'h05);
        if (!on_time) begin
            exp_err(88, ERR_PRE_EARLY);
            one_at(88, CMD_PRE, 3'd2, 2'd1);
        end
        one_at(89, CMD_PRE, 3'd2, 2'd1);
        chk("pre_closed_b9", bank_active[9], 0);
        if (on_time) begin
            pair_at(127, CMD_ACT0, 3'd2, 2'd1, 16'h4321, 6'd0);
            chk("act_at_trp_b9", bank_active[9], 1);
        end else begin
            exp_err(127, ERR_TRP);
            pair_at(126, CMD_ACT0, 3'd2, 2'd1, 16'h4321, 6'd0);
            chk("act_early_b9", bank_active[9], 0);
        end
        drain(135);
    endtask

    initial begin
        #12;
        chk("rst_bank_active", bank_active, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_err", {err_valid, err_code}, 0);
        chk("rst_wr", {wr_req, wr_done}, 0);

        scn_pre_act(1'b0);
        scn_pre_act(1'b1);

        // tRCD: one cycle early on bank 9, exactly on time on bank 6.
        do_reset();
        pair_at(0, CMD_ACT0, 3'd2, 2'd1, 16'h1234, 6'd0);
        pair_at(2, CMD_ACT0, 3'd1, 2'd2, 16'h0abc, 6'd0);
        exp_err(39, ERR_TRCD);
        pair_at(38, CMD_RD0, 3'd2, 2'd1, 16'd0, 6'h05);
        exp_rd(42, 16'h0abc, 3'd1, 2'd2, 6'h3f);
        pair_at(41, CMD_RD0, 3'd1, 2'd2, 16'd0, 6'h3f);
        drain(95);

        // Bank-state errors, write burst, busy collision on the last beat.
        do_reset();
        pair_at(0, CMD_ACT0, 3'd2, 2'd1, 16'h1234, 6'd0);
        pair_at(2, CMD_ACT0, 3'd3, 2'd0, 16'hbeef, 6'd0);
        chk("two_banks_open", bank_active, 32'h0000_1200);
        exp_err(5, ERR_BANK_OPEN);
        pair_at(4, CMD_ACT0, 3'd2, 2'd1, 16'h5555, 6'd0);
        exp_err(7, ERR_BANK_IDLE);
        pair_at(6, CMD_RD0, 3'd0, 2'd0, 16'd0, 6'h01);
        exp_err(8, ERR_BANK_IDLE);
        one_at(8, CMD_PRE, 3'd0, 2'd0);
        exp_err(9, ERR_PRE_EARLY);
        one_at(9, CMD_PRE, 3'd2, 2'd1);
        chk("errors_no_change", bank_active, 32'h0000_1200);
        exp_wr(41);
        pair_at(40, CMD_WR0, 3'd2, 2'd1, 16'd0, 6'h05);
        exp_err(88, ERR_BUSY);
        pair_at(87, CMD_WR0, 3'd3, 2'd0, 16'd0, 6'h07);
        exp_rd(90, 16'hbeef, 3'd3, 2'd0, 6'h07);
        pair_at(89, CMD_RD0, 3'd3, 2'd0, 16'd0, 6'h07);
        drain(140);

        // Broken pair, orphan second half, then reset during a read burst.
        do_reset();
        exp_err(1, ERR_PAIR);
        go_to(0);
        send(CMD_ACT0, 3'd0, 2'd0, 16'h1111, 6'd0);
        send(CMD_ACT1, 3'd1, 2'd0, 16'h1111, 6'd0);
        exp_err(2, ERR_PAIR);
        send(CMD_RD1, 3'd2, 2'd1, 16'd0, 6'h05);
        chk("pair_err_no_open", bank_active, 0);
        pair_at(3, CMD_ACT0, 3'd2, 2'd1, 16'h2222, 6'd0);
        chk("act_open_b9_d", bank_active[9], 1);
        exp_rd(44, 16'h2222, 3'd2, 2'd1, 6'h09);
        pair_at(43, CMD_RD0, 3'd2, 2'd1, 16'd0, 6'h09);
        go_to(86);
        chk("burst_live", rd_valid, 1);
        rst_n = 1'b0;
        clear_q();
        #1;
        chk("rst_mid_rd_valid", rd_valid, 0);
        chk("rst_mid_banks", bank_active, 0);
        chk("rst_mid_rd_data", rd_data, 0);
        repeat (2) @(posedge dimm_clk);
        #1 rst_n = 1'b1;
        base = cyc;
        drain(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
